// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and helpers for the pipeline sequencer: controller states,
// per-stage pause/flush vectors and the stage-group masks used to build them.
package pipeline_ctrl_pkg;

  parameter int PAUSE_STAGES = 7;

  typedef enum logic [1:0] {
    CTRL_RUN,
    CTRL_DRAIN,
    CTRL_IDLE_WAIT
  } ctrl_state_t;

  // Bit 0 is the fetch stage, so the first declared field is the MSB (mem).
  typedef struct packed {
    logic mem;
    logic execute;
    logic dispatch;
    logic decoder;
    logic buffer;
    logic icache;
    logic if_stage;
  } pause_t;

  typedef struct packed {
    logic mem;
    logic execute;
    logic dispatch;
    logic decoder;
    logic buffer;
    logic icache;
    logic if_stage;
  } flush_t;

  localparam logic [PAUSE_STAGES-1:0] STAGES_FRONT = 7'b001_1111;
  localparam logic [PAUSE_STAGES-1:0] STAGES_TO_EX = 7'b011_1111;
  localparam logic [PAUSE_STAGES-1:0] STAGES_ALL   = 7'b111_1111;

  // A stall in stage k holds every older stage too: bits 0..highest request.
  function automatic logic [PAUSE_STAGES-1:0] stall_mask(
    input logic [PAUSE_STAGES-1:0] req
  );
    logic [PAUSE_STAGES-1:0] mask;
    logic                    acc;
    mask = '0;
    acc  = 1'b0;
    for (int k = PAUSE_STAGES - 1; k >= 0; k--) begin
      acc     = acc | req[k];
      mask[k] = acc;
    end
    return mask;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Stall/flush/redirect bundle between the pipeline stages and the sequencer.
interface pipeline_ctrl_if;
  import pipeline_ctrl_pkg::*;

  logic [PAUSE_STAGES-1:0] stall_req_i;
  logic                    branch_flush_i;
  logic [31:0]             branch_target_i;
  logic                    excp_flush_i;
  logic [31:0]             excp_entry_i;
  logic                    ertn_flush_i;
  logic [31:0]             era_i;
  logic                    idle_i;
  logic [31:0]             idle_pc_i;
  logic                    int_pending_i;
  logic                    mem_req_i;
  logic                    mem_ack_i;
  pause_t                  pause_o;
  flush_t                  flush_o;
  logic                    redirect_valid_o;
  logic [31:0]             redirect_pc_o;

  modport master (
    output stall_req_i, branch_flush_i, branch_target_i, excp_flush_i,
           excp_entry_i, ertn_flush_i, era_i, idle_i, idle_pc_i,
           int_pending_i, mem_req_i, mem_ack_i,
    input  pause_o, flush_o, redirect_valid_o, redirect_pc_o
  );

  modport slave (
    input  stall_req_i, branch_flush_i, branch_target_i, excp_flush_i,
           excp_entry_i, ertn_flush_i, era_i, idle_i, idle_pc_i,
           int_pending_i, mem_req_i, mem_ack_i,
    output pause_o, flush_o, redirect_valid_o, redirect_pc_o
  );

endinterface

// File: rtl/pipeline_ctrl_mem_outstanding_cnt.sv
// Saturating up/down count of dcache requests still awaiting a response.
module mem_outstanding_cnt #(
  parameter int OUTS_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  input  logic              dec,
  output logic [OUTS_W-1:0] cnt_next,
  output logic              zero,
  output logic              full
);

  logic [OUTS_W-1:0] cnt_q;

  assign zero = (cnt_q == '0);
  assign full = (cnt_q == '1);

  // A spurious ack at zero and a request at full both leave the count alone.
  always_comb begin
    cnt_next = cnt_q;
    unique case ({inc, dec})
      2'b10:   if (!full) cnt_next = cnt_q + 1'b1;
      2'b01:   if (!zero) cnt_next = cnt_q - 1'b1;
      default: cnt_next = cnt_q;
    endcase
  end

  // NOTE: sequential state is written with non-blocking assignments only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_next;
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer: merges stall requests, orders flush/redirect events and
// holds exception/ertn redirects until all outstanding dcache traffic drains.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int OUTS_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  pipeline_ctrl_if.slave  ctl
);

  ctrl_state_t             state_q, state_d;
  logic [31:0]             target_q, target_d;
  logic [OUTS_W-1:0]       cnt_next;
  logic                    cnt_zero, cnt_full;
  logic [PAUSE_STAGES-1:0] pause_v, flush_v;
  logic                    redir_v;
  logic [31:0]             redir_pc, trap_pc;
  logic                    do_trap;

  mem_outstanding_cnt #(.OUTS_W(OUTS_W)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .inc      (ctl.mem_req_i),
    .dec      (ctl.mem_ack_i),
    .cnt_next (cnt_next),
    .zero     (cnt_zero),
    .full     (cnt_full)
  );

  // NOTE: every signal driven here gets a default first, so no latch is inferred.
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    flush_v  = '0;
    redir_v  = 1'b0;
    redir_pc = '0;
    trap_pc  = ctl.excp_flush_i ? ctl.excp_entry_i : ctl.era_i;
    do_trap  = ((state_q == CTRL_RUN) && (ctl.excp_flush_i || ctl.ertn_flush_i)) ||
               ((state_q == CTRL_IDLE_WAIT) && ctl.excp_flush_i);

    pause_v = stall_mask(ctl.stall_req_i);
    if (state_q == CTRL_DRAIN) pause_v = pause_v | STAGES_TO_EX;
    if ((state_q == CTRL_IDLE_WAIT) || cnt_full) pause_v = STAGES_ALL;

    if (do_trap) begin
      // Redirect at once only if no dcache access will still be in flight.
      if (cnt_next == '0) begin
        flush_v  = STAGES_ALL;
        redir_v  = 1'b1;
        redir_pc = trap_pc;
        state_d  = CTRL_RUN;
      end else begin
        flush_v  = STAGES_TO_EX;
        target_d = trap_pc;
        state_d  = CTRL_DRAIN;
      end
    end else begin
      unique case (state_q)
        CTRL_RUN: begin
          if (ctl.idle_i) begin
            flush_v  = STAGES_TO_EX;
            target_d = ctl.idle_pc_i + 32'd4;
            state_d  = CTRL_IDLE_WAIT;
          end else if (ctl.branch_flush_i) begin
            flush_v  = STAGES_FRONT;
            redir_v  = 1'b1;
            redir_pc = ctl.branch_target_i;
          end
        end
        CTRL_DRAIN: begin
          if (cnt_zero) begin
            flush_v  = STAGES_ALL;
            redir_v  = 1'b1;
            redir_pc = target_q;
            state_d  = CTRL_RUN;
          end
        end
        CTRL_IDLE_WAIT: begin
          if (ctl.int_pending_i && cnt_zero) begin
            redir_v  = 1'b1;
            redir_pc = target_q;
            state_d  = CTRL_RUN;
          end
        end
        default: state_d = CTRL_RUN;
      endcase
    end

    // A stage being flushed must not also be held.
    pause_v = pause_v & ~flush_v;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= CTRL_RUN;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
    end
  end

  // Outputs are forced quiet for as long as reset is held.
  assign ctl.pause_o          = rst ? pause_t'(pause_v) : '0;
  assign ctl.flush_o          = rst ? flush_t'(flush_v) : '0;
  assign ctl.redirect_valid_o = rst & redir_v;
  assign ctl.redirect_pc_o    = rst ? redir_pc : '0;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: per-cycle pause/flush checks plus a
// scoreboard of expected redirect targets popped whenever a redirect fires.
module tb_pipeline_ctrl;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;
  logic [31:0] sb[$];

  pipeline_ctrl_if ctl ();

  pipeline_ctrl dut (
    .clk (clk),
    .rst (rst),
    .ctl (ctl.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: sim time %0t, limit 50000", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    ctl.stall_req_i     = '0;
    ctl.branch_flush_i  = 1'b0;
    ctl.branch_target_i = '0;
    ctl.excp_flush_i    = 1'b0;
    ctl.excp_entry_i    = '0;
    ctl.ertn_flush_i    = 1'b0;
    ctl.era_i           = '0;
    ctl.idle_i          = 1'b0;
    ctl.idle_pc_i       = '0;
    ctl.int_pending_i   = 1'b0;
    ctl.mem_req_i       = 1'b0;
    ctl.mem_ack_i       = 1'b0;
  endtask

  // Inputs are set by the caller; this checks one cycle and then clears them.
  task automatic step(input string tag, input logic [6:0] ep, input logic [6:0] ef,
                      input logic er, input logic [31:0] epc);
    if (er) sb.push_back(epc);
    @(negedge clk);
    check({tag, ".pause"}, 32'(ctl.pause_o), 32'(ep));
    check({tag, ".flush"}, 32'(ctl.flush_o), 32'(ef));
    check({tag, ".redir_valid"}, 32'(ctl.redirect_valid_o), 32'(er));
    @(posedge clk);
    #1;
    clr();
  endtask

  // Every redirect the DUT produces must match the oldest expected target.
  always @(negedge clk) begin
    if (rst && ctl.redirect_valid_o) begin
      check("redir_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) check("redir_pc", ctl.redirect_pc_o, sb.pop_front());
    end
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    clr();
    rst = 1'b0;
    ctl.stall_req_i     = 7'h7F;
    ctl.branch_flush_i  = 1'b1;
    ctl.branch_target_i = 32'h1234_5678;
    ctl.excp_flush_i    = 1'b1;
    #2;
    check("rst.pause", 32'(ctl.pause_o), 32'd0);
    check("rst.flush", 32'(ctl.flush_o), 32'd0);
    check("rst.redir_valid", 32'(ctl.redirect_valid_o), 32'd0);
    check("rst.redir_pc", ctl.redirect_pc_o, 32'd0);
    clr();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Stall merging: pause everything up to the highest requester.
    ctl.stall_req_i = 7'b001_0000; step("stall_disp", 7'b001_1111, 7'h00, 1'b0, 0);
    ctl.stall_req_i = 7'b000_0001; step("stall_if",   7'b000_0001, 7'h00, 1'b0, 0);
    ctl.stall_req_i = 7'b100_0000; step("stall_mem",  7'b111_1111, 7'h00, 1'b0, 0);
    ctl.stall_req_i = 7'b010_0101; step("stall_mix",  7'b011_1111, 7'h00, 1'b0, 0);
    step("quiet", 7'h00, 7'h00, 1'b0, 0);

    // Branch mispredict with a decoder stall in the same cycle.
    ctl.branch_flush_i  = 1'b1;
    ctl.branch_target_i = 32'h1C00_0100;
    ctl.stall_req_i     = 7'b000_1000;
    step("branch", 7'h00, 7'b001_1111, 1'b1, 32'h1C00_0100);

    // Exception waits for two outstanding dcache requests.
    ctl.mem_req_i = 1'b1; step("req1", 7'h00, 7'h00, 1'b0, 0);
    ctl.mem_req_i = 1'b1; step("req2", 7'h00, 7'h00, 1'b0, 0);
    ctl.excp_flush_i = 1'b1;
    ctl.excp_entry_i = 32'h1C00_8000;
    step("excp_drain", 7'h00, 7'b011_1111, 1'b0, 0);
    ctl.branch_flush_i  = 1'b1;
    ctl.branch_target_i = 32'hBAD0_0001;
    ctl.excp_flush_i    = 1'b1;
    ctl.excp_entry_i    = 32'hBAD0_0002;
    step("drain_ignore", 7'b011_1111, 7'h00, 1'b0, 0);
    ctl.mem_ack_i = 1'b1; step("drain_ack1", 7'b011_1111, 7'h00, 1'b0, 0);
    ctl.mem_ack_i = 1'b1; step("drain_ack2", 7'b011_1111, 7'h00, 1'b0, 0);
    step("drain_done", 7'h00, 7'h7F, 1'b1, 32'h1C00_8000);
    step("drain_run", 7'h00, 7'h00, 1'b0, 0);

    // Priority: exception beats ertn, idle and branch in the same cycle.
    ctl.excp_flush_i    = 1'b1;
    ctl.excp_entry_i    = 32'h1C00_8000;
    ctl.branch_flush_i  = 1'b1;
    ctl.branch_target_i = 32'hBAD0_0003;
    step("excp_vs_branch", 7'h00, 7'h7F, 1'b1, 32'h1C00_8000);
    ctl.excp_flush_i = 1'b1;
    ctl.excp_entry_i = 32'h1C00_8040;
    ctl.ertn_flush_i = 1'b1;
    ctl.era_i        = 32'hBAD0_0004;
    ctl.idle_i       = 1'b1;
    step("excp_vs_all", 7'h00, 7'h7F, 1'b1, 32'h1C00_8040);
    ctl.ertn_flush_i = 1'b1;
    ctl.era_i        = 32'h1C00_0200;
    step("ertn", 7'h00, 7'h7F, 1'b1, 32'h1C00_0200);

    // Ack arriving with the exception makes the next count zero: no drain.
    ctl.mem_req_i = 1'b1; step("req_a", 7'h00, 7'h00, 1'b0, 0);
    ctl.mem_req_i = 1'b1; ctl.mem_ack_i = 1'b1; step("req_ack", 7'h00, 7'h00, 1'b0, 0);
    ctl.mem_ack_i    = 1'b1;
    ctl.excp_flush_i = 1'b1;
    ctl.excp_entry_i = 32'h1C00_8080;
    step("excp_ack_same", 7'h00, 7'h7F, 1'b1, 32'h1C00_8080);

    // Idle with an interrupt five cycles later; branch in the idle cycle is dropped.
    ctl.idle_i          = 1'b1;
    ctl.idle_pc_i       = 32'hFFFF_FFFC;
    ctl.branch_flush_i  = 1'b1;
    ctl.branch_target_i = 32'hBAD0_0005;
    step("idle", 7'h00, 7'b011_1111, 1'b0, 0);
    for (int i = 0; i < 4; i++) step($sformatf("idle_wait%0d", i), 7'h7F, 7'h00, 1'b0, 0);
    ctl.int_pending_i = 1'b1;
    step("idle_wake", 7'h7F, 7'h00, 1'b1, 32'h0000_0000);
    step("idle_run", 7'h00, 7'h00, 1'b0, 0);

    // Interrupt already pending at idle: exactly one IDLE_WAIT cycle.
    ctl.idle_i = 1'b1; ctl.idle_pc_i = 32'h1C00_0400; ctl.int_pending_i = 1'b1;
    step("idle_int", 7'h00, 7'b011_1111, 1'b0, 0);
    ctl.int_pending_i = 1'b1;
    step("idle_int_wake", 7'h7F, 7'h00, 1'b1, 32'h1C00_0404);
    step("idle_int_run", 7'h00, 7'h00, 1'b0, 0);

    // Exception pre-empts IDLE_WAIT.
    ctl.idle_i = 1'b1; ctl.idle_pc_i = 32'h1C00_0500;
    step("idle_x", 7'h00, 7'b011_1111, 1'b0, 0);
    ctl.excp_flush_i = 1'b1; ctl.excp_entry_i = 32'h1C00_C000;
    step("idle_excp", 7'h00, 7'h7F, 1'b1, 32'h1C00_C000);
    step("idle_excp_run", 7'h00, 7'h00, 1'b0, 0);

    // Fill the counter to 15: everything pauses until an ack arrives.
    for (int i = 0; i < 15; i++) begin
      ctl.mem_req_i = 1'b1;
      step($sformatf("fill%0d", i), 7'h00, 7'h00, 1'b0, 0);
    end
    step("full", 7'h7F, 7'h00, 1'b0, 0);
    ctl.branch_flush_i = 1'b1; ctl.branch_target_i = 32'h1C00_0800;
    step("full_branch", 7'b110_0000, 7'b001_1111, 1'b1, 32'h1C00_0800);
    ctl.mem_req_i = 1'b1; step("full_req", 7'h7F, 7'h00, 1'b0, 0);
    ctl.mem_ack_i = 1'b1; step("full_ack", 7'h7F, 7'h00, 1'b0, 0);
    step("unfull", 7'h00, 7'h00, 1'b0, 0);
    for (int i = 0; i < 15; i++) begin
      ctl.mem_ack_i = 1'b1;
      step($sformatf("empty%0d", i), 7'h00, 7'h00, 1'b0, 0);
    end
    ctl.excp_flush_i = 1'b1; ctl.excp_entry_i = 32'h1C00_8800;
    step("empty_excp", 7'h00, 7'h7F, 1'b1, 32'h1C00_8800);

    // Reset while draining with three requests outstanding.
    for (int i = 0; i < 3; i++) begin
      ctl.mem_req_i = 1'b1;
      step($sformatf("pre_rst%0d", i), 7'h00, 7'h00, 1'b0, 0);
    end
    ctl.excp_flush_i = 1'b1; ctl.excp_entry_i = 32'h1C00_9000;
    step("pre_rst_excp", 7'h00, 7'b011_1111, 1'b0, 0);
    rst = 1'b0;
    #1;
    check("rst_mid.pause", 32'(ctl.pause_o), 32'd0);
    check("rst_mid.flush", 32'(ctl.flush_o), 32'd0);
    check("rst_mid.redir_valid", 32'(ctl.redirect_valid_o), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    step("post_rst", 7'h00, 7'h00, 1'b0, 0);
    ctl.mem_ack_i = 1'b1;
    step("post_rst_ack", 7'h00, 7'h00, 1'b0, 0);
    step("post_rst_idle", 7'h00, 7'h00, 1'b0, 0);
    ctl.excp_flush_i = 1'b1; ctl.excp_entry_i = 32'h1C00_A000;
    step("post_rst_excp", 7'h00, 7'h7F, 1'b1, 32'h1C00_A000);
    step("tail", 7'h00, 7'h00, 1'b0, 0);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
